mem_stage_ctrl: RTL



---
 rtl/mem_stage_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: pipeline memory stage with a multi-cycle data array and a freeze (ready) handshake.
// Optional build macro MEM_RANGE_CHECK_EN: flags and suppresses accesses outside the mapped window
// through addr_err; without it word indices wrap modulo DEPTH.
module mem_stage_ctrl #(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_CYCLES = 3,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] st_val_in,
    input  logic [3:0]  dest_in,
    output logic        wb_en,
    output logic        mem_r_en,
    output logic [31:0] alu_res,
    output logic [3:0]  dest,
    output logic [31:0] mem_rdata,
`ifdef MEM_RANGE_CHECK_EN
    output logic        addr_err,
`endif
    output logic        ready
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] idx;
    logic          req, commit, blocked, we;

    assign wb_en    = wb_en_in;
    assign mem_r_en = mem_r_en_in;
    assign alu_res  = alu_res_in;
    assign dest     = dest_in;

    assign req = mem_r_en_in | mem_w_en_in;
    assign idx = AW'((alu_res_in - BASE_ADDR) >> 2);
`ifdef MEM_RANGE_CHECK_EN
    assign blocked = (alu_res_in < BASE_ADDR) || (((alu_res_in - BASE_ADDR) >> 2) >= 32'(DEPTH));
`else
    assign blocked = 1'b0;
`endif

    // The access takes effect on the edge that enters DONE; with no wait states that edge leaves IDLE.
    assign commit = (state_q == WAIT && cnt_q == LAST) || (WAIT_CYCLES == 0 && state_q == IDLE && req);
    assign we     = commit && mem_w_en_in && !blocked;

    assign ready     = state_q == DONE || (state_q == IDLE && !req);
    assign mem_rdata = rdata_q;

    // Next-state logic; the read register is only loaded on commit so it reads 0 outside DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = WAIT_CYCLES == 0 ? DONE : WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == LAST ? DONE : WAIT;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        rdata_d = (commit && mem_r_en_in && !mem_w_en_in && !blocked) ? mem_q[idx] : '0;
    end

    // State, wait counter and captured load data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Data array; a reset during WAIT drops any store that has not committed yet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we) begin
            mem_q[idx] <= st_val_in;
        end
    end

`ifdef MEM_RANGE_CHECK_EN
    logic err_q;

    // Range error is raised for exactly the DONE cycle of a blocked access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= commit && blocked;
    end

    assign addr_err = err_q;
`endif
endmodule
